// File: rtl/unified_mem_arbiter_if.sv
// Bundle of fetch-stage, memory-stage and external-memory signals around the
// unified memory arbiter. slave = arbiter view, master = environment view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic                  if_ready;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [1:0]            dm_size;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_ready;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [1:0]            mem_size;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  stall_if;
  logic                  stall_mem;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_we, dm_size, dm_addr, dm_wdata,
    input  mem_ack, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, if_flush,
    output dm_req, dm_we, dm_size, dm_addr, dm_wdata,
    output mem_ack, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  stall_if, stall_mem
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single unified memory port between fetch and memory stages,
// holding each granted request until mem_ack and producing the stage stalls.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  unified_mem_arbiter_if.slave    bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} state_t;

  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  state_t   state_q, state_d;
  logic     fetch_next_q, fetch_next_d;
  logic     killed_q, killed_d;
  mem_req_t req_q, req_d;
  logic     if_ready, dm_ready;
  logic     grant_data, grant_fetch;

  // Data wins a tie unless the last data completion left a fetch waiting.
  assign grant_data  = bus.dm_req & (~bus.if_req | ~fetch_next_q);
  assign grant_fetch = bus.if_req & ~grant_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_next_q <= 1'b0;
      killed_q     <= 1'b0;
      req_q        <= '0;
    end else begin
      state_q      <= state_d;
      fetch_next_q <= fetch_next_d;
      killed_q     <= killed_d;
      req_q        <= req_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_next_d = fetch_next_q;
    killed_d     = killed_q;
    req_d        = req_q;
    if_ready     = 1'b0;
    dm_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d = DATA;
          req_d   = '{we: bus.dm_we, size: bus.dm_size, addr: bus.dm_addr, wdata: bus.dm_wdata};
        end else if (grant_fetch) begin
          state_d      = FETCH;
          req_d        = '{we: 1'b0, size: 2'b00, addr: bus.if_addr, wdata: '0};
          fetch_next_d = 1'b0;
          killed_d     = bus.if_flush;
        end
      end
      FETCH: begin
        if (bus.if_flush) killed_d = 1'b1;
        // A flush landing on the ack cycle must also swallow that pulse.
        if (bus.mem_ack) begin
          if_ready = ~(killed_q | bus.if_flush);
          state_d  = IDLE;
          killed_d = 1'b0;
        end
      end
      DATA: begin
        if (bus.mem_ack) begin
          dm_ready = 1'b1;
          state_d  = IDLE;
          killed_d = 1'b0;
          if (bus.if_req) fetch_next_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_we    = req_q.we;
  assign bus.mem_size  = req_q.size;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;

  assign bus.if_ready  = if_ready;
  assign bus.dm_ready  = dm_ready;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;

  assign bus.stall_if  = bus.if_req & ~if_ready;
  assign bus.stall_mem = bus.dm_req & ~dm_ready;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: requesters push expected responses,
// a monitor pops them on each ready pulse; memory contents modelled separately.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // ---------------- reference and memory contents ----------------
  bit [31:0] mem_arr [bit [31:0]];
  bit [31:0] ref_mem [bit [31:0]];

  function automatic bit [31:0] init_val(input bit [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction
  function automatic bit [31:0] rd_mem(input bit [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return init_val(a);
  endfunction
  function automatic bit [31:0] rd_ref(input bit [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
  } dreq_t;

  dreq_t      d_q[$];
  bit [31:0]  f_q[$];
  dreq_t      d_cur;
  bit [31:0]  f_cur_addr;

  // ---------------- external memory model ----------------
  bit rand_wait = 1'b0;
  int fixed_wait = 0;
  bit spurious = 1'b0;
  bit mbusy;
  int mcnt;

  always @(negedge clk) begin
    if (!rst_n || !bus.mem_req) begin
      mbusy         = 1'b0;
      bus.mem_ack   = spurious && ($urandom_range(7) == 0);
      bus.mem_rdata = $urandom;
    end else begin
      if (!mbusy) begin
        mbusy = 1'b1;
        mcnt  = rand_wait ? int'($urandom_range(3)) : fixed_wait;
      end
      if (mcnt == 0) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          mem_arr[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata = $urandom;
        end else begin
          bus.mem_rdata = rd_mem(bus.mem_addr);
        end
      end else begin
        mcnt--;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int    cyc = 0;
  int    n_memreq, n_stall_if, n_ifready, n_dmready, last_dmr_cyc, fair_pend;
  string ack_log;
  bit    in_txn;
  logic [66:0] snap;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      in_txn = 1'b0;
    end else begin
      chk("stall_if", 128'(bus.stall_if), 128'(bus.if_req & ~bus.if_ready));
      chk("stall_mem", 128'(bus.stall_mem), 128'(bus.dm_req & ~bus.dm_ready));
      if (bus.mem_req) n_memreq++;
      if (bus.stall_if) n_stall_if++;
      if (bus.mem_req) begin
        if (!in_txn) begin
          snap   = {bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata};
          in_txn = 1'b1;
        end else begin
          chk("mem_fields_stable", 128'({bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata}), 128'(snap));
        end
      end else begin
        in_txn = 1'b0;
      end
      if (bus.if_ready) begin
        n_ifready++;
        if (f_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_ready_unexpected: got pulse expected none");
        end else begin
          chk("if_rdata", 128'(bus.if_rdata), 128'(f_q.pop_front()));
        end
      end
      if (bus.dm_ready) begin
        n_dmready++;
        last_dmr_cyc = cyc;
        if (d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dm_ready_unexpected: got pulse expected none");
        end else begin
          dreq_t e;
          e = d_q.pop_front();
          if (!e.we) chk("dm_rdata", 128'(bus.dm_rdata), 128'(e.rdata));
        end
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (bus.dm_ready) begin
          ack_log = {ack_log, "D"};
          chk("ack_fields_data", 128'({bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata}),
              128'({d_cur.we, d_cur.size, d_cur.addr, d_cur.wdata}));
          if (bus.if_req) begin
            fair_pend++;
            checks++;
            if (fair_pend > 1) begin
              errors++;
              $display("FAIL fetch_fairness: fetch waited %0d data txns expected at most 1", fair_pend);
            end
          end
        end else begin
          ack_log = {ack_log, "F"};
          chk("ack_fields_fetch", 128'({bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata}),
              128'({1'b0, 2'b00, f_cur_addr, 32'h0}));
          fair_pend = 0;
        end
      end
    end
  end

  task automatic clr_stats();
    n_memreq = 0; n_stall_if = 0; n_ifready = 0; n_dmready = 0;
    ack_log = ""; fair_pend = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the selected ready pulse; returns at the start of the next cycle.
  task automatic wait_ready(input bit sel_dm, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (sel_dm ? bus.dm_ready : bus.if_ready) begin done = 1'b1; break; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no ready expected ready within 200 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue_fetch(input bit [31:0] a);
    f_cur_addr  = a;
    f_q.push_back(rd_ref(a));
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    wait_ready(1'b0, "fetch");
    bus.if_req  = 1'b0;
  endtask

  task automatic issue_data(input bit we, input bit [1:0] sz, input bit [31:0] a, input bit [31:0] wd);
    dreq_t e;
    e.we = we; e.size = sz; e.addr = a; e.wdata = wd;
    e.rdata = we ? 32'h0 : rd_ref(a);
    if (we) ref_mem[a] = wd;
    d_cur = e;
    d_q.push_back(e);
    bus.dm_we = we; bus.dm_size = sz; bus.dm_addr = a; bus.dm_wdata = wd;
    bus.dm_req = 1'b1;
    wait_ready(1'b1, "data");
    bus.dm_req = 1'b0;
  endtask

  // Fetch that gets flushed dly cycles after the request cycle; no response expected.
  task automatic killed_fetch(input bit [31:0] a, input int dly);
    bit ack_seen = 1'b0;
    f_cur_addr  = a;
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      bus.if_flush = (c == dly);
      @(negedge clk); #2;
      ack_seen = bus.mem_req && bus.mem_ack;
      @(posedge clk); #1;
      if (ack_seen) break;
    end
    if (!ack_seen) begin
      checks++; errors++;
      $display("FAIL killed_fetch_timeout: got no mem_ack expected mem_ack");
    end
    bus.if_flush = 1'b0;
    bus.if_req   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int rq_cyc;
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_size = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    mem_arr[32'h10]  = 32'h0050_0093; ref_mem[32'h10]  = 32'h0050_0093;
    mem_arr[32'h100] = 32'hDEAD_BEEF; ref_mem[32'h100] = 32'hDEAD_BEEF;
    clr_stats();

    // Reset state
    cycles(3);
    chk("rst_mem_req", 128'(bus.mem_req), 128'(0));
    chk("rst_mem_fields", 128'({bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata}), 128'(0));
    chk("rst_readies", 128'({bus.if_ready, bus.dm_ready}), 128'(0));
    rst_n = 1'b1;
    cycles(1);

    // Fetch only, zero wait
    fixed_wait = 0;
    clr_stats();
    issue_fetch(32'h10);
    cycles(2);
    chk("t1_memreq_cycles", 128'(n_memreq), 128'(1));
    chk("t1_ifready_pulses", 128'(n_ifready), 128'(1));
    chk("t1_stall_if_cycles", 128'(n_stall_if), 128'(1));

    // Simultaneous requests after reset, 2 wait cycles
    do_reset();
    fixed_wait = 2;
    clr_stats();
    rq_cyc = cyc;
    fork
      issue_data(1'b0, 2'b10, 32'h100, 32'h0);
      issue_fetch(32'h20);
    join
    cycles(2);
    chk("t2_dm_ready_latency", 128'(last_dmr_cyc - rq_cyc), 128'(3));
    chk_str("t2_grant_order", ack_log, "DF");

    // Back-to-back stores with fetch held
    fixed_wait = 1;
    clr_stats();
    fork
      for (int k = 0; k < 3; k++) issue_data(1'b1, 2'b10, 32'h1000 + 32'(k * 4), $urandom);
      for (int k = 0; k < 2; k++) issue_fetch(32'h40 + 32'(k * 4));
    join
    cycles(2);
    chk_str("t3_grant_order", ack_log, "DFDFD");

    // Flush in a wait cycle, at grant, and on the ack cycle
    fixed_wait = 3;
    clr_stats();
    killed_fetch(32'h80, 2);
    cycles(2);
    chk("t4_memreq_cycles", 128'(n_memreq), 128'(4));
    chk("t4_no_ifready", 128'(n_ifready), 128'(0));
    chk("t4_back_to_idle", 128'(bus.mem_req), 128'(0));
    fixed_wait = 1;
    clr_stats();
    killed_fetch(32'h84, 0);
    cycles(1);
    chk("t4b_memreq_cycles", 128'(n_memreq), 128'(2));
    chk("t4b_no_ifready", 128'(n_ifready), 128'(0));
    fixed_wait = 0;
    clr_stats();
    killed_fetch(32'h88, 1);
    cycles(1);
    chk("t4c_no_ifready", 128'(n_ifready), 128'(0));
    clr_stats();
    issue_fetch(32'h8C);
    chk("t4d_fetch_resumes", 128'(n_ifready), 128'(1));

    // Reset mid-access
    fixed_wait = 6;
    bus.dm_we = 1'b0; bus.dm_size = 2'b10; bus.dm_addr = 32'h1004; bus.dm_wdata = 32'h0;
    bus.dm_req = 1'b1;
    cycles(3);
    chk("t5_in_data", 128'(bus.mem_req), 128'(1));
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_mem_req", 128'(bus.mem_req), 128'(0));
    chk("t5_async_dm_ready", 128'(bus.dm_ready), 128'(0));
    chk("t5_async_mem_addr", 128'(bus.mem_addr), 128'(0));
    bus.dm_req = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    fixed_wait = 0;
    clr_stats();
    issue_data(1'b0, 2'b10, 32'h1004, 32'h0);
    chk("t5_after_reset_grant", 128'(n_dmready), 128'(1));

    // Store field check, then read it back
    fixed_wait = 2;
    fork
      issue_data(1'b1, 2'b10, 32'h204, 32'h0000_00AB);
      begin
        repeat (2) @(negedge clk);
        #2;
        chk("t6_mem_req", 128'(bus.mem_req), 128'(1));
        chk("t6_store_fields", 128'({bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata}),
            128'({1'b1, 2'b10, 32'h204, 32'h0000_00AB}));
      end
    join
    issue_data(1'b0, 2'b10, 32'h204, 32'h0);

    // Randomized traffic with random waits and stray acks while idle
    rand_wait = 1'b1;
    spurious  = 1'b1;
    fork
      for (int k = 0; k < 40; k++) begin
        cycles($urandom_range(2));
        issue_fetch(32'($urandom_range(63)) * 4);
      end
      for (int k = 0; k < 40; k++) begin
        cycles($urandom_range(2));
        issue_data(1'($urandom_range(1)), 2'($urandom_range(3)),
                   32'h1000 + 32'($urandom_range(15)) * 4, $urandom);
      end
    join
    spurious = 1'b0;
    cycles(5);
    chk("fetch_queue_drained", 128'(f_q.size()), 128'(0));
    chk("data_queue_drained", 128'(d_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
